// File: rtl/fetch_issue_queue.sv
// Sequential fetch PC owner for one lane: issues orders to fetch, retries on miss,
// and buffers returned {pc,instr} pairs in a small FIFO for decode.
module fetch_issue_queue #(
  parameter int                     LEN_WORD  = 32,
  parameter int                     LEN_INST  = 32,
  parameter int                     LOG_DEPTH = 2,
  parameter logic [LEN_WORD-1:0]    RESET_PC  = '0
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_redirect_valid,
  input  logic [LEN_WORD-1:0] i_redirect_pc,
  input  logic                i_halt,
  output logic                o_fetch_order,
  output logic [LEN_WORD-1:0] o_fetch_pc,
  input  logic                i_fetch_done,
  input  logic [LEN_INST-1:0] i_fetch_instr,
  output logic                o_out_valid,
  output logic [LEN_WORD-1:0] o_out_pc,
  output logic [LEN_INST-1:0] o_out_instr,
  input  logic                i_out_ready,
  output logic [15:0]         o_miss_count
);

  localparam int DEPTH = 1 << LOG_DEPTH;
  localparam logic [LOG_DEPTH:0] FULL_COUNT = (LOG_DEPTH + 1)'(DEPTH);

  typedef enum logic {
    S_RUN,
    S_MISS
  } state_t;

  state_t                r_state;
  state_t                w_stateNext;
  logic [LEN_WORD-1:0]   r_pc;
  logic [LEN_WORD-1:0]   r_memPc    [DEPTH];
  logic [LEN_INST-1:0]   r_memInstr [DEPTH];
  logic [LOG_DEPTH-1:0]  r_rdPtr;
  logic [LOG_DEPTH-1:0]  r_wrPtr;
  logic [LOG_DEPTH:0]    r_count;
  logic [15:0]           r_missCount;

  logic                  w_order;
  logic                  w_push;
  logic                  w_miss;
  logic                  w_outValid;
  logic                  w_pop;

  // Issue uses the registered count, so a slot freed by a pop is only reused next cycle.
  always_comb begin
    w_order    = ~i_rst & ~i_halt & ~i_redirect_valid & (r_count < FULL_COUNT);
    w_push     = w_order & i_fetch_done;
    w_miss     = w_order & ~i_fetch_done;
    w_outValid = (r_count != '0);
    w_pop      = w_outValid & i_out_ready & ~i_redirect_valid;
  end

  always_comb begin
    w_stateNext = r_state;
    if (i_redirect_valid) begin
      w_stateNext = S_RUN;
    end else if (w_push) begin
      w_stateNext = S_RUN;
    end else if (w_miss) begin
      w_stateNext = S_MISS;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_RUN;
    end else begin
      r_state <= w_stateNext;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pc        <= RESET_PC;
      r_rdPtr     <= '0;
      r_wrPtr     <= '0;
      r_count     <= '0;
      r_missCount <= '0;
    end else begin
      if (w_miss && (r_missCount != 16'hFFFF)) begin
        r_missCount <= r_missCount + 16'd1;
      end
      if (i_redirect_valid) begin
        r_pc    <= i_redirect_pc & ~LEN_WORD'(3);
        r_rdPtr <= '0;
        r_wrPtr <= '0;
        r_count <= '0;
      end else begin
        if (w_push) begin
          r_pc    <= r_pc + LEN_WORD'(4);
          r_wrPtr <= r_wrPtr + LOG_DEPTH'(1);
        end
        if (w_pop) begin
          r_rdPtr <= r_rdPtr + LOG_DEPTH'(1);
        end
        r_count <= r_count + (LOG_DEPTH + 1)'(w_push) - (LOG_DEPTH + 1)'(w_pop);
      end
    end
  end

  // Storage needs no reset: entries are only observed while counted as valid.
  always_ff @(posedge i_clk) begin
    if (w_push && !i_rst) begin
      r_memPc[r_wrPtr]    <= r_pc;
      r_memInstr[r_wrPtr] <= i_fetch_instr;
    end
  end

  always_comb begin
    o_fetch_order = w_order;
    o_fetch_pc    = r_pc;
    o_out_valid   = w_outValid;
    o_out_pc      = w_outValid ? r_memPc[r_rdPtr] : '0;
    o_out_instr   = w_outValid ? r_memInstr[r_rdPtr] : '0;
    o_miss_count  = r_missCount;
  end

endmodule

// File: tb/tb_fetch_issue_queue.sv
// Directed bench for fetch_issue_queue; the fetch model returns pc ^ INSTR_KEY
// as the instruction so each buffered entry can be traced back to its PC.
module tb_fetch_issue_queue;

  localparam logic [31:0] INSTR_KEY = 32'hDEAD_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirectValid;
  logic [31:0] redirectPc;
  logic        halt;
  logic        fetchOrder;
  logic [31:0] fetchPc;
  logic        fetchDone;
  logic [31:0] fetchInstr;
  logic        outValid;
  logic [31:0] outPc;
  logic [31:0] outInstr;
  logic        outReady;
  logic [15:0] missCount;

  int nVectors     = 0;
  int nMiscompares = 0;

  always #5 clk = ~clk;

  assign fetchInstr = fetchPc ^ INSTR_KEY;

  fetch_issue_queue #(
    .LEN_WORD (32),
    .LEN_INST (32),
    .LOG_DEPTH(2),
    .RESET_PC (32'h0)
  ) dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_redirect_valid(redirectValid),
    .i_redirect_pc   (redirectPc),
    .i_halt          (halt),
    .o_fetch_order   (fetchOrder),
    .o_fetch_pc      (fetchPc),
    .i_fetch_done    (fetchDone),
    .i_fetch_instr   (fetchInstr),
    .o_out_valid     (outValid),
    .o_out_pc        (outPc),
    .o_out_instr     (outInstr),
    .i_out_ready     (outReady),
    .o_miss_count    (missCount)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst = 1'b1; halt = 1'b0; redirectValid = 1'b0; redirectPc = '0;
    fetchDone = 1'b1; outReady = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; halt = 1'b0; redirectValid = 1'b0; redirectPc = '0;
    fetchDone = 1'b1; outReady = 1'b1;
    tick();
    tick();
    #1;
    nVectors++;
    if (fetchOrder !== 1'b0) begin nMiscompares++; $display("[TB] FAIL reset_order got %b want 0", fetchOrder); end
    nVectors++;
    if (outValid !== 1'b0) begin nMiscompares++; $display("[TB] FAIL reset_valid got %b want 0", outValid); end
    nVectors++;
    if (outPc !== 32'h0) begin nMiscompares++; $display("[TB] FAIL reset_outpc got %h want 0", outPc); end
    nVectors++;
    if (outInstr !== 32'h0) begin nMiscompares++; $display("[TB] FAIL reset_outinstr got %h want 0", outInstr); end
    nVectors++;
    if (fetchPc !== 32'h0) begin nMiscompares++; $display("[TB] FAIL reset_pc got %h want 0", fetchPc); end
    nVectors++;
    if (missCount !== 16'h0) begin nMiscompares++; $display("[TB] FAIL reset_miss got %h want 0", missCount); end
  endtask

  // Continues straight out of reset: one push and one pop per cycle.
  task automatic test_stream();
    logic [31:0] expPc;
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      expPc = 32'(4 * k);
      #1;
      nVectors++;
      if (fetchOrder !== 1'b1) begin nMiscompares++; $display("[TB] FAIL stream_order[%0d] got %b want 1", k, fetchOrder); end
      nVectors++;
      if (fetchPc !== expPc) begin nMiscompares++; $display("[TB] FAIL stream_pc[%0d] got %h want %h", k, fetchPc, expPc); end
      nVectors++;
      if (outValid !== (k > 0)) begin nMiscompares++; $display("[TB] FAIL stream_valid[%0d] got %b want %b", k, outValid, (k > 0)); end
      if (k > 0) begin
        nVectors++;
        if (outPc !== expPc - 32'd4) begin nMiscompares++; $display("[TB] FAIL stream_outpc[%0d] got %h want %h", k, outPc, expPc - 32'd4); end
        nVectors++;
        if (outInstr !== ((expPc - 32'd4) ^ INSTR_KEY)) begin nMiscompares++; $display("[TB] FAIL stream_instr[%0d] got %h want %h", k, outInstr, (expPc - 32'd4) ^ INSTR_KEY); end
      end
      tick();
    end
    nVectors++;
    if (missCount !== 16'h0) begin nMiscompares++; $display("[TB] FAIL stream_miss got %h want 0", missCount); end
  endtask

  task automatic test_miss_retry();
    doReset();
    outReady = 1'b1;
    fetchDone = 1'b1;
    repeat (4) tick();
    fetchDone = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      nVectors++;
      if (fetchPc !== 32'h10) begin nMiscompares++; $display("[TB] FAIL miss_pc[%0d] got %h want 10", k, fetchPc); end
      nVectors++;
      if (fetchOrder !== 1'b1) begin nMiscompares++; $display("[TB] FAIL miss_order[%0d] got %b want 1", k, fetchOrder); end
      tick();
    end
    nVectors++;
    if (missCount !== 16'd3) begin nMiscompares++; $display("[TB] FAIL miss_count got %0d want 3", missCount); end
    fetchDone = 1'b1;
    tick();
    #1;
    nVectors++;
    if (fetchPc !== 32'h14) begin nMiscompares++; $display("[TB] FAIL miss_nextpc got %h want 14", fetchPc); end
    nVectors++;
    if (outValid !== 1'b1 || outPc !== 32'h10) begin nMiscompares++; $display("[TB] FAIL miss_head got v=%b pc=%h want v=1 pc=10", outValid, outPc); end
  endtask

  task automatic test_full();
    doReset();
    outReady = 1'b0;
    fetchDone = 1'b1;
    repeat (4) tick();
    #1;
    nVectors++;
    if (fetchOrder !== 1'b0) begin nMiscompares++; $display("[TB] FAIL full_order got %b want 0", fetchOrder); end
    nVectors++;
    if (fetchPc !== 32'h10) begin nMiscompares++; $display("[TB] FAIL full_pc got %h want 10", fetchPc); end
    tick();
    #1;
    nVectors++;
    if (fetchPc !== 32'h10 || fetchOrder !== 1'b0) begin nMiscompares++; $display("[TB] FAIL full_hold got pc=%h ord=%b want pc=10 ord=0", fetchPc, fetchOrder); end
    outReady = 1'b1;
    #1;
    nVectors++;
    if (outPc !== 32'h0 || fetchOrder !== 1'b0) begin nMiscompares++; $display("[TB] FAIL full_pop got head=%h ord=%b want head=0 ord=0", outPc, fetchOrder); end
    tick();
    #1;
    nVectors++;
    if (fetchOrder !== 1'b1 || fetchPc !== 32'h10) begin nMiscompares++; $display("[TB] FAIL full_resume got ord=%b pc=%h want ord=1 pc=10", fetchOrder, fetchPc); end
    nVectors++;
    if (outPc !== 32'h4) begin nMiscompares++; $display("[TB] FAIL full_nexthead got %h want 4", outPc); end
  endtask

  task automatic test_redirect();
    doReset();
    outReady = 1'b0;
    fetchDone = 1'b1;
    repeat (3) tick();
    redirectValid = 1'b1;
    redirectPc = 32'h103;
    outReady = 1'b1;
    #1;
    nVectors++;
    if (fetchOrder !== 1'b0) begin nMiscompares++; $display("[TB] FAIL redir_order got %b want 0", fetchOrder); end
    tick();
    redirectValid = 1'b0;
    #1;
    nVectors++;
    if (outValid !== 1'b0) begin nMiscompares++; $display("[TB] FAIL redir_flush got %b want 0", outValid); end
    nVectors++;
    if (fetchPc !== 32'h100) begin nMiscompares++; $display("[TB] FAIL redir_pc got %h want 100", fetchPc); end
  endtask

  task automatic test_halt();
    doReset();
    outReady = 1'b0;
    fetchDone = 1'b1;
    repeat (2) tick();
    halt = 1'b1;
    outReady = 1'b1;
    #1;
    nVectors++;
    if (fetchOrder !== 1'b0 || outPc !== 32'h0) begin nMiscompares++; $display("[TB] FAIL halt_order got ord=%b head=%h want ord=0 head=0", fetchOrder, outPc); end
    tick();
    #1;
    nVectors++;
    if (fetchPc !== 32'h8 || outValid !== 1'b1 || outPc !== 32'h4) begin nMiscompares++; $display("[TB] FAIL halt_pop got pc=%h v=%b head=%h want pc=8 v=1 head=4", fetchPc, outValid, outPc); end
    tick();
    #1;
    nVectors++;
    if (outValid !== 1'b0 || fetchPc !== 32'h8) begin nMiscompares++; $display("[TB] FAIL halt_drain got v=%b pc=%h want v=0 pc=8", outValid, fetchPc); end
    redirectValid = 1'b1;
    redirectPc = 32'h40;
    tick();
    redirectValid = 1'b0;
    #1;
    nVectors++;
    if (fetchPc !== 32'h40 || fetchOrder !== 1'b0) begin nMiscompares++; $display("[TB] FAIL halt_redir got pc=%h ord=%b want pc=40 ord=0", fetchPc, fetchOrder); end
    halt = 1'b0;
    #1;
    nVectors++;
    if (fetchOrder !== 1'b1) begin nMiscompares++; $display("[TB] FAIL halt_release got %b want 1", fetchOrder); end
  endtask

  task automatic test_wrap_saturate();
    doReset();
    outReady = 1'b1;
    fetchDone = 1'b1;
    redirectValid = 1'b1;
    redirectPc = 32'hFFFF_FFFF;
    tick();
    redirectValid = 1'b0;
    #1;
    nVectors++;
    if (fetchPc !== 32'hFFFF_FFFC || fetchOrder !== 1'b1) begin nMiscompares++; $display("[TB] FAIL wrap_start got pc=%h ord=%b want pc=fffffffc ord=1", fetchPc, fetchOrder); end
    tick();
    #1;
    nVectors++;
    if (fetchPc !== 32'h0) begin nMiscompares++; $display("[TB] FAIL wrap_pc got %h want 0", fetchPc); end
    nVectors++;
    if (outPc !== 32'hFFFF_FFFC) begin nMiscompares++; $display("[TB] FAIL wrap_head got %h want fffffffc", outPc); end
    fetchDone = 1'b0;
    repeat (65534) tick();
    nVectors++;
    if (missCount !== 16'hFFFE) begin nMiscompares++; $display("[TB] FAIL sat_pre got %h want fffe", missCount); end
    tick();
    nVectors++;
    if (missCount !== 16'hFFFF) begin nMiscompares++; $display("[TB] FAIL sat_hit got %h want ffff", missCount); end
    repeat (2) tick();
    nVectors++;
    if (missCount !== 16'hFFFF) begin nMiscompares++; $display("[TB] FAIL sat_hold got %h want ffff", missCount); end
    redirectValid = 1'b1;
    redirectPc = 32'h200;
    tick();
    redirectValid = 1'b0;
    #1;
    nVectors++;
    if (missCount !== 16'hFFFF || fetchPc !== 32'h200) begin nMiscompares++; $display("[TB] FAIL sat_redir got miss=%h pc=%h want miss=ffff pc=200", missCount, fetchPc); end
  endtask

  task automatic test_reset_mid_miss();
    doReset();
    outReady = 1'b0;
    fetchDone = 1'b1;
    repeat (3) tick();
    fetchDone = 1'b0;
    repeat (2) tick();
    #1;
    nVectors++;
    if (missCount !== 16'd2 || outValid !== 1'b1) begin nMiscompares++; $display("[TB] FAIL rstmiss_pre got miss=%0d v=%b want miss=2 v=1", missCount, outValid); end
    rst = 1'b1;
    #1;
    nVectors++;
    if (fetchOrder !== 1'b0) begin nMiscompares++; $display("[TB] FAIL rstmiss_order got %b want 0", fetchOrder); end
    tick();
    rst = 1'b0;
    fetchDone = 1'b1;
    #1;
    nVectors++;
    if (fetchPc !== 32'h0 || outValid !== 1'b0) begin nMiscompares++; $display("[TB] FAIL rstmiss_state got pc=%h v=%b want pc=0 v=0", fetchPc, outValid); end
    nVectors++;
    if (missCount !== 16'h0 || fetchOrder !== 1'b1) begin nMiscompares++; $display("[TB] FAIL rstmiss_post got miss=%h ord=%b want miss=0 ord=1", missCount, fetchOrder); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_miss_retry();
    test_full();
    test_redirect();
    test_halt();
    test_wrap_saturate();
    test_reset_mid_miss();
    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule
